// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode values and control FSM states.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_NOR   = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1010;
  localparam logic [3:0] OP_MFHI  = 4'b1011;
  localparam logic [3:0] OP_ORI   = 4'b1100;
  localparam logic [3:0] OP_LUI   = 4'b1101;
  localparam logic [3:0] OP_ADDI  = 4'b1110;
  localparam logic [3:0] OP_MFLO  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN_MUL = 2'd1,
    RUN_DIV = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mc_if.sv
// Issue/result bundle between the execute-stage control unit (master) and the ALU (slave).
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             start;
  logic [3:0]       ALUOperation;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [SHW-1:0]   shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic             Overflow;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output start, ALUOperation, A, B, shamt,
    input  busy, done, ALUResult, Zero, Overflow, HI, LO
  );

  modport slave (
    input  start, ALUOperation, A, B, shamt,
    output busy, done, ALUResult, Zero, Overflow, HI, LO
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative engine: shift-add unsigned multiply, and (when ALU_DIV_EN is defined)
// restoring unsigned divide, one bit per clock for WIDTH clocks.
// finish is a strobe on the last iteration; hi_res/lo_res are the values that
// iteration produces, so the caller can capture them on that same edge.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
`ifdef ALU_DIV_EN
  input  logic             load_div,
`endif
  input  logic             run,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             finish,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);
  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] operand_reg;
  logic [WIDTH-1:0] acc_hi_reg;
  logic [WIDTH-1:0] acc_lo_reg;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [WIDTH:0]   mul_sum;

  // Multiply: acc_hi holds the partial product, acc_lo the unconsumed multiplier bits.
  assign mul_sum = {1'b0, acc_hi_reg} + {1'b0, operand_reg};

`ifdef ALU_DIV_EN
  logic           div_mode_reg;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_trial;

  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  // The partial remainder is always below the divisor, so div_shift never needs bit WIDTH
  // except transiently; a zero divisor always "fits" and yields an all-ones quotient.
  assign div_shift = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, operand_reg};
`endif

  // One iteration of whichever algorithm is active.
  always_comb begin
    step_hi = acc_hi_reg;
    step_lo = acc_lo_reg;
`ifdef ALU_DIV_EN
    if (div_mode_reg) begin
      if (!div_trial[WIDTH]) begin
        step_hi = div_trial[WIDTH-1:0];
        step_lo = {acc_lo_reg[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {acc_lo_reg[WIDTH-2:0], 1'b0};
      end
    end else
`endif
    if (acc_lo_reg[0]) begin
      {step_hi, step_lo} = {mul_sum, acc_lo_reg[WIDTH-1:1]};
    end else begin
      {step_hi, step_lo} = {1'b0, acc_hi_reg, acc_lo_reg[WIDTH-1:1]};
    end
  end

  // Operand latch on issue, then advance one iteration per clock while running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg    <= '0;
      operand_reg  <= '0;
      acc_hi_reg   <= '0;
      acc_lo_reg   <= '0;
`ifdef ALU_DIV_EN
      div_mode_reg <= 1'b0;
`endif
    end else if (load) begin
      count_reg    <= '0;
      acc_hi_reg   <= '0;
`ifdef ALU_DIV_EN
      div_mode_reg <= load_div;
      operand_reg  <= load_div ? b : a;
      acc_lo_reg   <= load_div ? a : b;
`else
      operand_reg  <= a;
      acc_lo_reg   <= b;
`endif
    end else if (run) begin
      count_reg  <= count_reg + CW'(1);
      acc_hi_reg <= step_hi;
      acc_lo_reg <= step_lo;
    end
  end

  assign finish = run && (count_reg == CW'(WIDTH - 1));
  assign hi_res = step_hi;
  assign lo_res = step_lo;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU. Single-cycle ops complete at the accepting edge;
// MULTU (and DIVU when ALU_DIV_EN is defined) run WIDTH clocks in alu_muldiv_seq
// and hold busy high meanwhile. Without ALU_DIV_EN, DIVU completes immediately with 0.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  alu_mc_if.slave  bus
);
  localparam int HALF = WIDTH / 2;

  state_t           state_reg;
  state_t           state_next;
  logic             load;
  logic             load_div;
  logic             single_wr;
  logic             run;
  logic             finish;
  logic [WIDTH-1:0] hi_res;
  logic [WIDTH-1:0] lo_res;

  logic [WIDTH-1:0] result_reg;
  logic             zero_reg;
  logic             overflow_reg;
  logic             done_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] res;
  logic             ovf;

  assign run = (state_reg != IDLE);

  alu_muldiv_seq #(.WIDTH(WIDTH)) u_seq (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
`ifdef ALU_DIV_EN
    .load_div (load_div),
`endif
    .run      (run),
    .a        (bus.A),
    .b        (bus.B),
    .finish   (finish),
    .hi_res   (hi_res),
    .lo_res   (lo_res)
  );

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Issue decode and next state; start is only looked at in IDLE.
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    load_div   = 1'b0;
    single_wr  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          if (bus.ALUOperation == OP_MULTU) begin
            load       = 1'b1;
            state_next = RUN_MUL;
          end
`ifdef ALU_DIV_EN
          else if (bus.ALUOperation == OP_DIVU) begin
            load       = 1'b1;
            load_div   = 1'b1;
            state_next = RUN_DIV;
          end
`endif
          else begin
            single_wr = 1'b1;
          end
        end
      end
      RUN_MUL, RUN_DIV: begin
        if (finish) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign sum  = bus.A + bus.B;
  assign diff = bus.A - bus.B;

  // Single-cycle result and signed-overflow flag.
  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (bus.ALUOperation)
      OP_AND:  res = bus.A & bus.B;
      OP_OR:   res = bus.A | bus.B;
      OP_NOR:  res = ~(bus.A | bus.B);
      OP_ADD, OP_ADDI: begin
        res = sum;
        ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB: begin
        res = diff;
        ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SLL:  res = bus.A << bus.shamt;
      OP_SRL:  res = bus.A >> bus.shamt;
      OP_SRA:  res = WIDTH'($signed(bus.A) >>> bus.shamt);
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      OP_MFHI: res = hi_reg;
      OP_MFLO: res = lo_reg;
      OP_ORI:  res = bus.A | bus.B;
      OP_LUI:  res = {bus.B[HALF-1:0], {HALF{1'b0}}};
      default: res = '0;  // MULTU never lands here; DIVU does only when the divider is absent
    endcase
  end

  // Result, flag, done and HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_reg   <= '0;
      zero_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      done_reg     <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
    end else begin
      done_reg <= 1'b0;
      if (single_wr) begin
        result_reg   <= res;
        zero_reg     <= (res == '0);
        overflow_reg <= ovf;
        done_reg     <= 1'b1;
      end else if (finish) begin
        hi_reg       <= hi_res;
        lo_reg       <= lo_res;
        result_reg   <= lo_res;
        zero_reg     <= (lo_res == '0);
        overflow_reg <= 1'b0;
        done_reg     <= 1'b1;
      end
    end
  end

  assign bus.busy      = run;
  assign bus.done      = done_reg;
  assign bus.ALUResult = result_reg;
  assign bus.Zero      = zero_reg;
  assign bus.Overflow  = overflow_reg;
  assign bus.HI        = hi_reg;
  assign bus.LO        = lo_reg;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32): directed plan steps followed by
// random operations, all checked against an arithmetic reference model.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W = 32;
`ifdef ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(W)) bus ();
  alu_mc #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [31:0] hi_m = 32'h0;
  logic [31:0] lo_m = 32'h0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference for every op that completes in the accepting cycle: {overflow, result}.
  function automatic logic [32:0] ref_single(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [4:0] sh);
    longint sa, sb, r;
    logic [31:0] res;
    logic ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 0;
    res = 32'h0;
    ov = 1'b0;
    case (op)
      OP_AND:  res = a & b;
      OP_OR, OP_ORI: res = a | b;
      OP_NOR:  res = ~(a | b);
      OP_ADD, OP_ADDI: begin
        r = sa + sb; res = 32'(r); ov = (r != longint'($signed(res)));
      end
      OP_SUB: begin
        r = sa - sb; res = 32'(r); ov = (r != longint'($signed(res)));
      end
      OP_SLL:  res = a << sh;
      OP_SRL:  res = a >> sh;
      OP_SRA:  res = 32'(sa >>> sh);
      OP_SLT:  res = (sa < sb) ? 32'd1 : 32'd0;
      OP_LUI:  res = 32'(b % 65536) * 32'd65536;
      OP_MFHI: res = hi_m;
      OP_MFLO: res = lo_m;
      default: res = 32'h0;
    endcase
    return {ov, res};
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    @(negedge clk);
    bus.start = 1'b1;
    bus.ALUOperation = op;
    bus.A = a;
    bus.B = b;
    bus.shamt = sh;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic do_single(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sh);
    logic [32:0] e;
    e = ref_single(op, a, b, sh);
    drive(op, a, b, sh);
    $display("%s op=%b A=%h B=%h sh=%0d -> res=%h Z=%b V=%b", tag, op, a, b, sh,
             bus.ALUResult, bus.Zero, bus.Overflow);
    chk({tag, ".done"}, 64'(bus.done), 64'd1);
    chk({tag, ".res"}, 64'(bus.ALUResult), 64'(e[31:0]));
    chk({tag, ".zero"}, 64'(bus.Zero), 64'(e[31:0] == 32'h0));
    chk({tag, ".ovf"}, 64'(bus.Overflow), 64'(e[32]));
    chk({tag, ".busy"}, 64'(bus.busy), 64'd0);
    chk({tag, ".hilo"}, {bus.HI, bus.LO}, {hi_m, lo_m});
    @(posedge clk);
    #1;
    chk({tag, ".done_drop"}, 64'(bus.done), 64'd0);
  endtask

  // Multi-cycle op; operand inputs are scrambled after issue, and optionally an
  // ADD issue is attempted while busy, neither of which may affect the outcome.
  task automatic do_multi(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit inject);
    logic [63:0] p;
    logic [31:0] eh, el;
    int n;
    if (op == OP_MULTU) begin
      p = 64'(a) * 64'(b);
      eh = p[63:32];
      el = p[31:0];
    end else if (b == 32'h0) begin
      eh = a;
      el = 32'hFFFF_FFFF;
    end else begin
      eh = a % b;
      el = a / b;
    end
    drive(op, a, b, 5'd0);
    chk({tag, ".busy_on"}, 64'(bus.busy), 64'd1);
    chk({tag, ".no_early_done"}, 64'(bus.done), 64'd0);
    bus.A = $urandom;
    bus.B = $urandom;
    n = 0;
    while (n < 40 && !bus.done) begin
      if (inject && n == 3) begin
        bus.start = 1'b1;
        bus.ALUOperation = OP_ADD;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    bus.start = 1'b0;
    hi_m = eh;
    lo_m = el;
    $display("%s op=%b A=%h B=%h cycles=%0d -> HI=%h LO=%h", tag, op, a, b, n, bus.HI, bus.LO);
    chk({tag, ".cycles"}, 64'(n), 64'd32);
    chk({tag, ".done"}, 64'(bus.done), 64'd1);
    chk({tag, ".busy_off"}, 64'(bus.busy), 64'd0);
    chk({tag, ".hilo"}, {bus.HI, bus.LO}, {eh, el});
    chk({tag, ".res"}, 64'(bus.ALUResult), 64'(el));
    chk({tag, ".zero"}, 64'(bus.Zero), 64'(el == 32'h0));
    chk({tag, ".ovf"}, 64'(bus.Overflow), 64'd0);
    @(posedge clk);
    #1;
    chk({tag, ".done_once"}, 64'(bus.done), 64'd0);
    chk({tag, ".res_hold"}, 64'(bus.ALUResult), 64'(el));
  endtask

  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh);
    if (op == OP_MULTU || (op == OP_DIVU && DIV_EN)) do_multi(tag, op, a, b, 1'b0);
    else do_single(tag, op, a, b, sh);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.ALUOperation = OP_AND;
    bus.A = '0;
    bus.B = '0;
    bus.shamt = '0;
    #2;
    chk("reset.outs", {bus.HI, bus.LO}, 64'h0);
    chk("reset.flags", {32'h0, bus.ALUResult, 1'b0, bus.busy, bus.done, bus.Zero, bus.Overflow},
        64'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    do_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0);
    do_op("sub_zero", OP_SUB, 32'h5, 32'h5, 5'd0);
    do_op("sub_ovf", OP_SUB, 32'h8000_0000, 32'h1, 5'd0);
    do_op("sra", OP_SRA, 32'h8000_0000, 32'h0, 5'd4);
    do_op("slt", OP_SLT, 32'hFFFF_FFFF, 32'h1, 5'd0);
    do_op("lui", OP_LUI, 32'h1234_5678, 32'h0000_ABCD, 5'd0);
    do_multi("multu_inject", OP_MULTU, 32'hFFFF_FFFF, 32'h2, 1'b1);
    do_op("mfhi", OP_MFHI, 32'h0, 32'h0, 5'd0);
    do_op("mflo", OP_MFLO, 32'h0, 32'h0, 5'd0);
    do_op("divu", OP_DIVU, 32'd100, 32'd7, 5'd0);
    do_op("divu_by0", OP_DIVU, 32'h1234, 32'h0, 5'd0);

    // Reset in the middle of a multiply: everything clears at once.
    drive(OP_MULTU, 32'hFFFF_FFFF, 32'h2, 5'd0);
    repeat (10) @(posedge clk);
    #2;
    chk("midrst.busy_before", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    #1;
    hi_m = 32'h0;
    lo_m = 32'h0;
    $display("midrst busy=%b done=%b HI=%h LO=%h res=%h", bus.busy, bus.done, bus.HI, bus.LO,
             bus.ALUResult);
    chk("midrst.hilo", {bus.HI, bus.LO}, 64'h0);
    chk("midrst.flags", {32'h0, bus.ALUResult, 1'b0, bus.busy, bus.done, bus.Zero, bus.Overflow},
        64'h0);
    @(negedge clk);
    reset = 1'b0;
    do_op("add_after_rst", OP_ADD, 32'd20, 32'd22, 5'd0);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      do_op($sformatf("rnd%0d", i), op, a, b, 5'($urandom_range(0, 31)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
